// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet FIFO for the arbitrated beat stream.
// A packet becomes visible on the master side only once its last beat is
// stored, so a consumer stall never shows up mid-packet. When a packet is
// longer than the buffer, the full condition opens the output as well. The
// packet then cuts through instead of deadlocking.
module stream_packet_fifo #(
   parameter int T_DATA_WIDTH = 4,
   parameter int T_QOS__WIDTH = 2,
   parameter int STREAM_COUNT = 3,
   parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
   parameter int DEPTH        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [T_DATA_WIDTH-1:0]    s_data_in,
   input  logic [T_QOS__WIDTH-1:0]    s_qos_in,
   input  logic [T_ID___WIDTH-1:0]    s_id_in,
   input  logic                       s_last_in,
   input  logic                       s_valid_in,
   output logic                       s_ready_out,
   output logic [T_DATA_WIDTH-1:0]    m_data_out,
   output logic [T_QOS__WIDTH-1:0]    m_qos_out,
   output logic [T_ID___WIDTH-1:0]    m_id_out,
   output logic                       m_last_out,
   output logic                       m_valid_out,
   input  logic                       m_ready_in,
   output logic [$clog2(DEPTH+1)-1:0] level_out,
   output logic [$clog2(DEPTH+1)-1:0] pkt_cnt_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int ENT_W = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1;

   // Entry layout: {data, qos, id, last}; last sits in bit 0.
   logic [ENT_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

   logic             full;
   logic             wr_en;
   logic             rd_en;
   logic             wr_last;
   logic             rd_last;
   logic [ENT_W-1:0] head;

   // Full is taken from the registered level only. A pop in the same cycle
   // does not free a slot for a write until the next cycle.
   assign full        = (level_q == CNT_W'(DEPTH));
   assign s_ready_out = ~full;
   assign wr_en       = s_valid_in & s_ready_out;

   // First-word-fall-through head. The last flag is gated by valid so that
   // stale RAM contents never show a spurious last after reset.
   assign head        = mem_q[rd_ptr_q];
   assign m_valid_out = (pkt_cnt_q != '0) | full;
   assign m_data_out  = head[ENT_W-1 -: T_DATA_WIDTH];
   assign m_qos_out   = head[T_ID___WIDTH+1 +: T_QOS__WIDTH];
   assign m_id_out    = head[1 +: T_ID___WIDTH];
   assign m_last_out  = m_valid_out & head[0];
   assign rd_en       = m_valid_out & m_ready_in;

   assign wr_last     = wr_en & s_last_in;
   assign rd_last     = rd_en & head[0];

   assign level_out   = level_q;
   assign pkt_cnt_out = pkt_cnt_q;

   // Next-state for pointers, beat level and complete-packet count.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      pkt_cnt_d = pkt_cnt_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase
      case ({wr_last, rd_last})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   // Control state. Reset drops every buffered beat at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         pkt_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   // Beat storage. It is not cleared on reset, because the pointers and
   // counters alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {s_data_in, s_qos_in, s_id_in, s_last_in};
   end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Scoreboard bench for stream_packet_fifo: accepted beats are queued as
// expectations and a negedge monitor checks every handshaken output beat.
module tb_stream_packet_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] s_data_in = '0;
   logic [1:0] s_qos_in = '0;
   logic [1:0] s_id_in = '0;
   logic       s_last_in = 1'b0;
   logic       s_valid_in = 1'b0;
   logic       s_ready_out;
   logic [3:0] m_data_out;
   logic [1:0] m_qos_out;
   logic [1:0] m_id_out;
   logic       m_last_out;
   logic       m_valid_out;
   logic       m_ready_in = 1'b0;
   logic [4:0] level_out;
   logic [4:0] pkt_cnt_out;

   int total = 0;
   int bad   = 0;
   logic [8:0] exp_q[$];   // {data, qos, id, last}

   stream_packet_fifo dut (
      .clk(clk), .rst(rst),
      .s_data_in(s_data_in), .s_qos_in(s_qos_in), .s_id_in(s_id_in),
      .s_last_in(s_last_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
      .m_data_out(m_data_out), .m_qos_out(m_qos_out), .m_id_out(m_id_out),
      .m_last_out(m_last_out), .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
      .level_out(level_out), .pkt_cnt_out(pkt_cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: a beat presented with valid&ready at the negedge is popped at
   // the following posedge, so compare it against the scoreboard head now.
   always @(negedge clk) begin
      logic [8:0] got;
      logic [8:0] want;
      if (!rst && m_valid_out && m_ready_in) begin
         got = {m_data_out, m_qos_out, m_id_out, m_last_out};
         if (exp_q.size() == 0) begin
            check("unexpected_beat", int'(got), -1);
         end else begin
            want = exp_q.pop_front();
            check("beat", int'(got), int'(want));
            $display("pop data=%h qos=%0d id=%0d last=%0d", m_data_out, m_qos_out, m_id_out, m_last_out);
         end
      end
   end

   // Drive one beat and hold it until accepted (bounded).
   task automatic push(input logic [3:0] d, input logic [1:0] q, input logic [1:0] id, input logic l);
      int  n;
      bit  acc;
      s_data_in  = d;
      s_qos_in   = q;
      s_id_in    = id;
      s_last_in  = l;
      s_valid_in = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = s_ready_out;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc) exp_q.push_back({d, q, id, l});
      else check("push_timeout", 0, 1);
      s_valid_in = 1'b0;
   endtask

   // Wait until the scoreboard and the FIFO are both empty (bounded).
   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || level_out != 0) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, int'(level_out) + exp_q.size(), 0);
   endtask

   initial begin
      logic [3:0] t1_data [4];
      bit         seen16;
      t1_data = '{4'h3, 4'hA, 4'h5, 4'hC};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_s_ready", s_ready_out, 1);
      check("rst_m_valid", m_valid_out, 0);
      check("rst_m_last", m_last_out, 0);
      check("rst_level", level_out, 0);
      check("rst_pkt_cnt", pkt_cnt_out, 0);

      // 1: single 4-beat packet, consumer ready
      m_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(t1_data[i], 2'd2, 2'd1, i == 3);
         if (i < 3) check("t1_valid_early", m_valid_out, 0);
      end
      check("t1_valid_after_last", m_valid_out, 1);
      check("t1_pkt_cnt_1", pkt_cnt_out, 1);
      drain("t1_drain");
      check("t1_pkt_cnt_0", pkt_cnt_out, 0);

      // 2: two packets buffered with consumer stalled
      m_ready_in = 1'b0;
      for (int i = 0; i < 8; i++)
         push(4'(i + 1), 2'(i / 4), (i < 4) ? 2'd0 : 2'd2, (i % 4) == 3);
      check("t2_level", level_out, 8);
      check("t2_pkt_cnt", pkt_cnt_out, 2);
      check("t2_s_ready", s_ready_out, 1);
      m_ready_in = 1'b1;
      drain("t2_drain");

      // 3: fill with 16 single-beat packets, 17th held until one pop
      m_ready_in = 1'b0;
      for (int i = 0; i < 16; i++)
         push(4'(15 - i), 2'(i % 4), 2'(i % 3), 1'b1);
      check("t3_level_full", level_out, 16);
      check("t3_s_ready_full", s_ready_out, 0);
      check("t3_m_valid_full", m_valid_out, 1);
      s_data_in = 4'h5; s_qos_in = 2'd3; s_id_in = 2'd2; s_last_in = 1'b1; s_valid_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("t3_held_level", level_out, 16);
      m_ready_in = 1'b1;             // one pop; no same-cycle write while full
      @(posedge clk);
      #1;
      m_ready_in = 1'b0;
      check("t3_after_pop_level", level_out, 15);
      check("t3_after_pop_s_ready", s_ready_out, 1);
      @(posedge clk);
      #1;
      exp_q.push_back({4'h5, 2'd3, 2'd2, 1'b1});
      s_valid_in = 1'b0;
      check("t3_17th_level", level_out, 16);
      m_ready_in = 1'b1;
      drain("t3_drain");

      // 4: simultaneous last write and last pop with pkt_cnt=1
      m_ready_in = 1'b0;
      push(4'h7, 2'd1, 2'd0, 1'b1);
      push(4'h8, 2'd1, 2'd1, 1'b0);
      check("t4_pre_pkt_cnt", pkt_cnt_out, 1);
      s_data_in = 4'h9; s_qos_in = 2'd1; s_id_in = 2'd1; s_last_in = 1'b1; s_valid_in = 1'b1;
      m_ready_in = 1'b1;
      exp_q.push_back({4'h9, 2'd1, 2'd1, 1'b1});
      @(posedge clk);
      #1;
      s_valid_in = 1'b0;
      m_ready_in = 1'b0;
      check("t4_pkt_cnt", pkt_cnt_out, 1);
      check("t4_level", level_out, 2);
      m_ready_in = 1'b1;
      drain("t4_drain");

      // 5: 20-beat packet overflows DEPTH and cuts through
      m_ready_in = 1'b1;
      seen16 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         push(4'(i), 2'd3, 2'd2, i == 19);
         if (!seen16 && level_out == 16) begin
            seen16 = 1'b1;
            check("t5_valid_at_full", m_valid_out, 1);
            check("t5_no_last_at_full", m_last_out, 0);
         end
      end
      check("t5_reached_full", int'(seen16), 1);
      drain("t5_drain");

      // 6: reset with beats buffered and ready toggling
      m_ready_in = 1'b0;
      for (int i = 0; i < 6; i++)
         push(4'(i + 10), 2'd0, 2'(i / 3), (i % 3) == 2);
      for (int i = 0; i < 3; i++) begin
         m_ready_in = ~m_ready_in;
         @(posedge clk);
         #1;
      end
      check("t6_pre_level", level_out, 4);
      m_ready_in = 1'b1;
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      check("t6_rst_level", level_out, 0);
      check("t6_rst_pkt_cnt", pkt_cnt_out, 0);
      check("t6_rst_m_valid", m_valid_out, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      check("t6_rel_s_ready", s_ready_out, 1);
      push(4'hE, 2'd2, 2'd1, 1'b0);
      push(4'hF, 2'd2, 2'd1, 1'b1);
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
